// File: rtl/mycpu_pkg.sv
// Shared fetch-path definitions: datapath width, default buffer depth and the
// {pc, inst} pair carried from the instruction SRAM to decode.
package mycpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/mycpu_fetch_fifo.sv
// Circular FIFO of fetch entries with a synchronous clear. Exposes the
// occupancy count and the head entry directly, so readers see no extra latency.
module mycpu_fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  mycpu_pkg::fetch_entry_t       i_entry,
    input  logic                          i_pop,
    input  logic                          i_clear,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output mycpu_pkg::fetch_entry_t       o_head
);
    import mycpu_pkg::*;

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;

    // Pointers are exactly log2(DEPTH) bits, so wrap-around is the natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_entry;
                r_tail        <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

endmodule

// File: rtl/mycpu_fetch_buffer.sv
// Fetch buffer between the PC unit and decode: issues SRAM reads, tracks the one
// in-flight return, queues {pc, inst} pairs and back-pressures the PC unit.
module mycpu_fetch_buffer #(
    parameter int unsigned DEPTH = mycpu_pkg::DEPTH,
    parameter int unsigned XLEN  = mycpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC,
    input  logic            instRequest,
    input  logic            flush,
    output logic            allowIN,
    output logic            inst_sram_en,
    output logic [XLEN-1:0] inst_sram_addr,
    input  logic [XLEN-1:0] inst_sram_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_allowin
);
    import mycpu_pkg::*;

    localparam int unsigned  CntW     = $clog2(DEPTH + 1);
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

    logic            w_pop;
    logic            w_issue;
    logic            w_push;
    logic [CntW-1:0] w_count;
    logic [CntW:0]   w_occ_after;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;

    logic            r_pending;
    logic [XLEN-1:0] r_pending_pc;

    assign w_pop = id_valid & id_allowin;

    // In-flight return counts against capacity so the FIFO can never overflow.
    assign w_occ_after = {1'b0, w_count} + {{CntW{1'b0}}, r_pending}
                       - {{CntW{1'b0}}, w_pop};

    assign allowIN        = flush | (w_occ_after < DepthLim);
    assign w_issue        = instRequest & allowIN & ~flush;
    assign inst_sram_en   = w_issue;
    assign inst_sram_addr = PC;

    // A return landing in the redirect cycle belongs to the wrong path.
    assign w_push     = r_pending & ~flush;
    assign w_entry.pc   = r_pending_pc;
    assign w_entry.inst = inst_sram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pending_pc <= PC;
            end
        end
    end

    mycpu_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_clear (flush),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign id_valid = (w_count != '0);
    assign id_pc    = w_head.pc;
    assign id_inst  = w_head.inst;

endmodule

// File: tb/tb_mycpu_fetch_buffer.sv
// Directed bench for the fetch buffer: a DEPTH=2 instance for the main scenarios
// and a DEPTH=4 instance for the fill/back-pressure boundary.
module tb_mycpu_fetch_buffer;

    logic        clk;
    logic        rst;

    logic [31:0] pc, rdata, sram_addr, id_pc, id_inst;
    logic        req, flush, allow_in, sram_en, id_valid, id_allowin;

    logic [31:0] pc4, rdata4, sram_addr4, id_pc4, id_inst4;
    logic        req4, flush4, allow_in4, sram_en4, id_valid4, id_allowin4;

    int checks = 0;
    int errors = 0;

    mycpu_fetch_buffer #(
        .DEPTH (2),
        .XLEN  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (pc),
        .instRequest     (req),
        .flush           (flush),
        .allowIN         (allow_in),
        .inst_sram_en    (sram_en),
        .inst_sram_addr  (sram_addr),
        .inst_sram_rdata (rdata),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_allowin      (id_allowin)
    );

    mycpu_fetch_buffer #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut4 (
        .clk             (clk),
        .rst             (rst),
        .PC              (pc4),
        .instRequest     (req4),
        .flush           (flush4),
        .allowIN         (allow_in4),
        .inst_sram_en    (sram_en4),
        .inst_sram_addr  (sram_addr4),
        .inst_sram_rdata (rdata4),
        .id_valid        (id_valid4),
        .id_pc           (id_pc4),
        .id_inst         (id_inst4),
        .id_allowin      (id_allowin4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: SRAM returns addr+0x1000 a cycle after a read; PC unit advances on issue.
    task automatic tick();
        logic        f2, f4;
        logic [31:0] a2, a4;
        #1;
        f2 = sram_en;
        a2 = sram_addr;
        f4 = sram_en4;
        a4 = sram_addr4;
        @(posedge clk);
        #1;
        rdata  = f2 ? a2 + 32'h1000 : 32'hDEAD_BEEF;
        rdata4 = f4 ? a4 + 32'h1000 : 32'hDEAD_BEEF;
        if (f2) pc = pc + 32'h4;
        if (f4) pc4 = pc4 + 32'h4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;

        rst = 1'b0;
        pc = '0; req = 1'b0; flush = 1'b0; rdata = '0; id_allowin = 1'b0;
        pc4 = '0; req4 = 1'b0; flush4 = 1'b0; rdata4 = '0; id_allowin4 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_allow", allow_in, 1'b1);
        chk("rst_en", sram_en, 1'b0);
        chk("rst_valid4", id_valid4, 1'b0);
        rst = 1'b1;

        // Streaming 0x0, 0x4, 0x8
        pc = 32'h0; req = 1'b1; id_allowin = 1'b1;
        #1;
        chk("s_en0", sram_en, 1'b1);
        chk("s_addr0", sram_addr, 32'h0);
        tick(); #1;
        chk("s_valid_e1", id_valid, 1'b0);
        chk("s_allow_e1", allow_in, 1'b1);
        tick(); #1;
        chk("s_valid_e2", id_valid, 1'b1);
        chk("s_pc_e2", id_pc, 32'h0);
        chk("s_inst_e2", id_inst, 32'h1000);
        chk("s_allow_e2", allow_in, 1'b1);
        tick(); req = 1'b0; #1;
        chk("s_pc_e3", id_pc, 32'h4);
        chk("s_inst_e3", id_inst, 32'h1004);
        chk("s_allow_e3", allow_in, 1'b1);
        tick(); #1;
        chk("s_valid_e4", id_valid, 1'b1);
        chk("s_pc_e4", id_pc, 32'h8);
        chk("s_inst_e4", id_inst, 32'h1008);
        tick(); #1;
        chk("s_empty", id_valid, 1'b0);

        // Stall: ID refuses, FIFO fills to 2 and back-pressure engages
        pc = 32'h0; req = 1'b1; id_allowin = 1'b0;
        #1;
        tick(); #1;
        chk("st_allow_e1", allow_in, 1'b1);
        tick(); #1;
        chk("st_allow_e2", allow_in, 1'b0);
        chk("st_en_e2", sram_en, 1'b0);
        chk("st_valid_e2", id_valid, 1'b1);
        tick(); #1;
        chk("st_pc_e3", id_pc, 32'h0);
        chk("st_allow_e3", allow_in, 1'b0);
        chk("st_en_e3", sram_en, 1'b0);
        tick(); #1;
        chk("st_pc_e4", id_pc, 32'h0);
        chk("st_allow_e4", allow_in, 1'b0);
        id_allowin = 1'b1; req = 1'b0;
        #1;
        chk("st_allow_rel", allow_in, 1'b1);
        chk("st_inst_rel", id_inst, 32'h1000);
        tick(); #1;
        chk("st_pc_2nd", id_pc, 32'h4);
        chk("st_inst_2nd", id_inst, 32'h1004);
        tick(); #1;
        chk("st_empty", id_valid, 1'b0);

        // Flush kills the in-flight return of 0x8, redirect to 0x40
        pc = 32'h8; req = 1'b1; id_allowin = 1'b1;
        #1;
        tick();
        flush = 1'b1; pc = 32'h40;
        #1;
        chk("f_en_flush", sram_en, 1'b0);
        chk("f_allow_flush", allow_in, 1'b1);
        tick(); flush = 1'b0; #1;
        chk("f_valid_after", id_valid, 1'b0);
        chk("f_en_redir", sram_en, 1'b1);
        chk("f_addr_redir", sram_addr, 32'h40);
        tick(); req = 1'b0; #1;
        chk("f_valid_e1", id_valid, 1'b0);
        tick(); #1;
        chk("f_valid_e2", id_valid, 1'b1);
        chk("f_pc_e2", id_pc, 32'h40);
        chk("f_inst_e2", id_inst, 32'h1040);
        tick(); #1;
        chk("f_empty", id_valid, 1'b0);

        // Eight back-to-back entries: push and pop together, pointers wrap
        pc = 32'h100; req = 1'b1; id_allowin = 1'b1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pc == 32'h120) req = 1'b0;
            #1;
            if (k >= 2 && k <= 9) begin
                exp_pc = 32'h100 + 32'(4 * (k - 2));
                chk("w_valid", id_valid, 1'b1);
                chk("w_pc", id_pc, exp_pc);
                chk("w_inst", id_inst, exp_pc + 32'h1000);
            end else begin
                chk("w_idle", id_valid, 1'b0);
            end
            chk("w_allow", allow_in, 1'b1);
        end

        // Asynchronous reset with one entry queued and one return in flight
        pc = 32'h200; req = 1'b1; id_allowin = 1'b0;
        #1;
        tick();
        tick(); #1;
        chk("r_valid_pre", id_valid, 1'b1);
        chk("r_allow_pre", allow_in, 1'b0);
        rst = 1'b0; req = 1'b0;
        #1;
        chk("r_valid_async", id_valid, 1'b0);
        chk("r_allow_async", allow_in, 1'b1);
        chk("r_pc_async", id_pc, 32'h0);
        chk("r_inst_async", id_inst, 32'h0);
        rst = 1'b1;
        rdata = 32'h1204;
        tick(); #1;
        chk("r_stale_dropped", id_valid, 1'b0);

        // DEPTH=4: fills to four, allowIN falls exactly at occupancy 4
        pc4 = 32'h300; req4 = 1'b1; id_allowin4 = 1'b0;
        #1;
        tick();
        tick(); #1;
        chk("d4_allow_occ2", allow_in4, 1'b1);
        tick(); #1;
        chk("d4_allow_occ3", allow_in4, 1'b1);
        chk("d4_en_occ3", sram_en4, 1'b1);
        tick(); #1;
        chk("d4_allow_occ4", allow_in4, 1'b0);
        chk("d4_en_occ4", sram_en4, 1'b0);
        tick(); #1;
        chk("d4_valid_full", id_valid4, 1'b1);
        chk("d4_pc_full", id_pc4, 32'h300);
        chk("d4_allow_full", allow_in4, 1'b0);
        id_allowin4 = 1'b1; req4 = 1'b0;
        #1;
        chk("d4_allow_rel", allow_in4, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(); #1;
            exp_pc = 32'h300 + 32'(4 * k);
            chk("d4_pc_drain", id_pc4, exp_pc);
            chk("d4_inst_drain", id_inst4, exp_pc + 32'h1000);
        end
        tick(); #1;
        chk("d4_empty", id_valid4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
